// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM encoding and the full-adder cell for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-bit full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple-carry adder with carry-in, chained from full-adder cells.
module nibble_adder_cin
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum_c,
    output logic             cout_c
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign {c[i+1], sum_c[i]} = full_add(a[i], b[i], c[i]);
    end

    assign cout_c = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB nibble first, valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int unsigned NIBS     = WIDTH / NIB_W;
    localparam int unsigned IDX_W    = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;
    logic             last;

    // Operands are shifted right so the active nibble always sits at bit 0.
    nibble_adder_cin u_nib (
        .a      (a_sh[NIB_W-1:0]),
        .b      (b_sh[NIB_W-1:0]),
        .cin    (carry),
        .sum_c  (nib_sum),
        .cout_c (nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        last       = (idx == LAST_IDX);
        // New nibble enters at the top; after NIBS steps nibble 0 lands at the bottom.
        psum_next  = WIDTH'({nib_sum, psum} >> NIB_W);
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= 1'b0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIB_W;
                    b_sh  <= b_sh >> NIB_W;
                    psum  <= psum_next;
                    carry <= nib_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        out_sum <= {nib_cout, psum_next};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16 and WIDTH=4) against a cycle-level behavioural model.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst16, rst4;
    logic        iv16, ir16, ov16, ord16, busy16;
    logic [15:0] a16, b16;
    logic [16:0] s16;
    logic        iv4, ir4, ov4, ord4, busy4;
    logic [3:0]  a4, b4;
    logic [4:0]  s4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .out_valid(ov16), .out_ready(ord16), .out_sum(s16), .busy(busy16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .out_valid(ov4), .out_ready(ord4), .out_sum(s4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted pair produces a+b exactly NIBS edges later, held until consumed.
    logic        mv16, mr16;
    logic [16:0] ms16, mp16;
    int          mc16;
    always @(posedge clk or posedge rst16) begin
        if (rst16) begin
            mv16 <= 1'b0; mr16 <= 1'b1; ms16 <= '0; mp16 <= '0; mc16 <= 0;
        end else if (mr16) begin
            if (iv16) begin mr16 <= 1'b0; mc16 <= 4; mp16 <= 17'(a16) + 17'(b16); end
        end else if (!mv16) begin
            if (mc16 == 1) begin mv16 <= 1'b1; ms16 <= mp16; end
            mc16 <= mc16 - 1;
        end else if (ord16) begin
            mv16 <= 1'b0; mr16 <= 1'b1;
        end
    end

    logic        mv4, mr4;
    logic [4:0]  ms4, mp4;
    int          mc4;
    always @(posedge clk or posedge rst4) begin
        if (rst4) begin
            mv4 <= 1'b0; mr4 <= 1'b1; ms4 <= '0; mp4 <= '0; mc4 <= 0;
        end else if (mr4) begin
            if (iv4) begin mr4 <= 1'b0; mc4 <= 1; mp4 <= 5'(a4) + 5'(b4); end
        end else if (!mv4) begin
            if (mc4 == 1) begin mv4 <= 1'b1; ms4 <= mp4; end
            mc4 <= mc4 - 1;
        end else if (ord4) begin
            mv4 <= 1'b0; mr4 <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid16", 17'(ov16),   17'(mv16));
        chk("cyc_ready16", 17'(ir16),   17'(mr16));
        chk("cyc_busy16",  17'(busy16), 17'(!mr16));
        chk("cyc_sum16",   s16,         ms16);
        chk("cyc_valid4",  17'(ov4),    17'(mv4));
        chk("cyc_ready4",  17'(ir4),    17'(mr4));
        chk("cyc_busy4",   17'(busy4),  17'(!mr4));
        chk("cyc_sum4",    17'(s4),     17'(ms4));
    end

    // Called at posedge+2; returns at posedge+2 after the result handshake edge.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp, input int hold);
        int n;
        n = 0;
        a16 = a; b16 = b; iv16 = 1'b1; ord16 = (hold == 0);
        while (!ir16 && n < 40) begin @(posedge clk); #2; n++; end
        chk("accept_ready16", 17'(ir16), 17'd1);
        @(posedge clk); #2;
        iv16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
        n = 0;
        while (!ov16 && n < 40) begin @(posedge clk); #2; n++; end
        chk("latency16", 17'(n), 17'd4);
        chk("result16", s16, exp);
        for (int i = 0; i < hold; i++) begin
            iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222;
            @(posedge clk); #2;
            chk("hold_sum16",   s16,         exp);
            chk("hold_valid16", 17'(ov16),   17'd1);
            chk("hold_ready16", 17'(ir16),   17'd0);
        end
        ord16 = 1'b1;
        @(posedge clk); #2;
        chk("ready_after16", 17'(ir16), 17'd1);
        chk("valid_after16", 17'(ov16), 17'd0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
        int n;
        n = 0;
        a4 = a; b4 = b; iv4 = 1'b1; ord4 = 1'b1;
        while (!ir4 && n < 20) begin @(posedge clk); #2; n++; end
        chk("accept_ready4", 17'(ir4), 17'd1);
        @(posedge clk); #2;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        n = 0;
        while (!ov4 && n < 20) begin @(posedge clk); #2; n++; end
        chk("latency4", 17'(n), 17'd1);
        chk("result4", 17'(s4), 17'(exp));
        @(posedge clk); #2;
        chk("ready_after4", 17'(ir4), 17'd1);
    endtask

    initial begin
        rst16 = 1'b1; rst4 = 1'b1;
        iv16 = 1'b0; ord16 = 1'b0; a16 = '0; b16 = '0;
        iv4 = 1'b0;  ord4 = 1'b0;  a4 = '0;  b4 = '0;
        repeat (3) @(posedge clk);
        #2;
        rst16 = 1'b0; rst4 = 1'b0;
        chk("reset_ready16", 17'(ir16),   17'd1);
        chk("reset_valid16", 17'(ov16),   17'd0);
        chk("reset_busy16",  17'(busy16), 17'd0);
        chk("reset_sum16",   s16,         17'h00000);
        chk("reset_sum4",    17'(s4),     17'h00);

        op16(16'h1234, 16'h4321, 17'h05555, 0);
        op16(16'hFFFF, 16'h0001, 17'h10000, 0);
        op16(16'hFFFF, 16'hFFFF, 17'h1FFFE, 0);
        op16(16'h00FF, 16'h0001, 17'h00100, 5);
        op16(16'h1111, 16'h2222, 17'h03333, 0);

        // Reset during the second RUN cycle of 0x8888+0x8888.
        a16 = 16'h8888; b16 = 16'h8888; iv16 = 1'b1;
        @(posedge clk); #2;
        iv16 = 1'b0;
        @(posedge clk); #3;
        rst16 = 1'b1;
        #1;
        chk("midrst_valid16", 17'(ov16),   17'd0);
        chk("midrst_sum16",   s16,         17'h00000);
        chk("midrst_busy16",  17'(busy16), 17'd0);
        #4;
        rst16 = 1'b0;
        @(posedge clk); #2;
        chk("postrst_ready16", 17'(ir16), 17'd1);
        op16(16'h0001, 16'h0002, 17'h00003, 0);

        op4(4'hE, 4'hF, 5'h1D);
        op4(4'h3, 4'h4, 5'h07);
        op4(4'h8, 4'h8, 5'h10);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
